pool_window_feeder: RTL and testbench

Streaming front-end for the 2x2 average-pooling unit. It accepts a convolution feature map one pixel per handshake in raster order and buffers one row pair. Whenever a 2x2 window is complete, it presents the window to `pooling_2x2` over its start/finish interface. It captures the pooled pixel and emits it on a valid/ready output stream, so it is the initiator side of the pooling unit's start/finish protocol.

---
 rtl/pool_pkg.sv | 22 ++
 rtl/pool_line_buffer.sv | 28 ++
 rtl/pool_window_feeder.sv | 180 ++++++++++++++++++
 tb/tb_pool_window_feeder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types, FSM encoding and default frame geometry for the 2x2 pooling front-end.
package pool_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned IMG_W_DEF  = 28;
  localparam int unsigned IMG_H_DEF  = 28;

  typedef logic [DATA_W_DEF-1:0] pixel_t;

  // Horizontal pixel pair from an even row: even column in the upper half.
  typedef struct packed {
    pixel_t even_px;
    pixel_t odd_px;
  } pair_t;

  typedef enum logic [1:0] {
    S_RECV = 2'd0,
    S_POOL = 2'd1,
    S_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/pool_line_buffer.sv
// Holds the even row as horizontal pixel pairs until the matching odd row arrives.
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = IMG_W_DEF / 2,
  parameter int unsigned AW     = 4
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [2*DATA_W-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [2*DATA_W-1:0] rd_data
);

  logic [2*DATA_W-1:0] mem_q [DEPTH];

  // Storage is never cleared; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pool_window_feeder.sv
// Raster-order pixel feeder: buffers a row pair, presents each 2x2 window to
// pooling_2x2 over start/finish, and streams the pooled result out.
module pool_window_feeder
  import pool_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              pool_start,
  output logic [DATA_W-1:0] pool_p00,
  output logic [DATA_W-1:0] pool_p01,
  output logic [DATA_W-1:0] pool_p10,
  output logic [DATA_W-1:0] pool_p11,
  input  logic              pool_finish,
  input  logic [DATA_W-1:0] pool_pixel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned LB_D  = IMG_W / 2;
  localparam int unsigned LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  state_t state_q, state_d;

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] p00_q, p00_d, p01_q, p01_d, p10_q, p10_d, p11_q, p11_d;
  logic              win_last_q, win_last_d;
  logic              in_ready_q, in_ready_d;
  logic              pool_start_q, pool_start_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic                in_hs;
  logic                win_px;
  logic                lb_we;
  logic [LB_AW-1:0]    lb_idx;
  logic [2*DATA_W-1:0] lb_wdata;
  logic [2*DATA_W-1:0] lb_rdata;

  assign in_hs  = in_valid & in_ready_q;
  assign win_px = in_hs & row_q[0] & col_q[0];
  assign lb_idx = LB_AW'(col_q >> 1);

  pool_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (LB_D),
    .AW     (LB_AW)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (lb_we),
    .wr_addr (lb_idx),
    .wr_data (lb_wdata),
    .rd_addr (lb_idx),
    .rd_data (lb_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RECV;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RECV:  if (win_px)      state_d = S_POOL;
      S_POOL:  if (pool_finish) state_d = S_OUT;
      S_OUT:   if (out_ready)   state_d = S_RECV;
      default:                  state_d = S_RECV;
    endcase
  end

  // Outputs are decoded from the next state so they align with the state register.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    p00_d        = p00_q;
    p01_d        = p01_q;
    p10_d        = p10_q;
    p11_d        = p11_q;
    win_last_d   = win_last_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    lb_we        = 1'b0;
    lb_wdata     = {hold_q, in_data};
    in_ready_d   = (state_d == S_RECV);
    pool_start_d = (state_d == S_POOL);
    out_valid_d  = (state_d == S_OUT);

    if (in_hs) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end

      if (!col_q[0]) begin
        hold_d = in_data;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        p00_d      = lb_rdata[2*DATA_W-1:DATA_W];
        p01_d      = lb_rdata[DATA_W-1:0];
        p10_d      = hold_q;
        p11_d      = in_data;
        win_last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
    end

    if ((state_q == S_POOL) && pool_finish) begin
      out_data_d = pool_pixel;
      out_last_d = win_last_q;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      p00_q        <= '0;
      p01_q        <= '0;
      p10_q        <= '0;
      p11_q        <= '0;
      win_last_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      pool_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      p00_q        <= p00_d;
      p01_q        <= p01_d;
      p10_q        <= p10_d;
      p11_q        <= p11_d;
      win_last_q   <= win_last_d;
      in_ready_q   <= in_ready_d;
      pool_start_q <= pool_start_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign pool_start = pool_start_q;
  assign pool_p00   = p00_q;
  assign pool_p01   = p01_q;
  assign pool_p10   = p10_q;
  assign pool_p11   = p11_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Self-checking bench for pool_window_feeder: 4x4 frames against a block-mean model
// with a delay-programmable pooling stub, plus one default 28x28 frame.
`timescale 1ns/1ps
module tb_pool_window_feeder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // 4x4 instance
  logic        in_valid4, in_ready4, pool_start4, pool_finish4, out_valid4, out_last4, out_ready4;
  logic [15:0] in_data4, p00_4, p01_4, p10_4, p11_4, pool_pixel4, out_data4;
  // default 28x28 instance
  logic        in_valid28, in_ready28, pool_start28, pool_finish28, out_valid28, out_last28, out_ready28;
  logic [15:0] in_data28, p00_28, p01_28, p10_28, p11_28, pool_pixel28, out_data28;

  pool_window_feeder #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
    .pool_start(pool_start4), .pool_p00(p00_4), .pool_p01(p01_4), .pool_p10(p10_4), .pool_p11(p11_4),
    .pool_finish(pool_finish4), .pool_pixel(pool_pixel4),
    .out_valid(out_valid4), .out_data(out_data4), .out_last(out_last4), .out_ready(out_ready4)
  );

  pool_window_feeder dut28 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid28), .in_data(in_data28), .in_ready(in_ready28),
    .pool_start(pool_start28), .pool_p00(p00_28), .pool_p01(p01_28), .pool_p10(p10_28), .pool_p11(p11_28),
    .pool_finish(pool_finish28), .pool_pixel(pool_pixel28),
    .out_valid(out_valid28), .out_data(out_data28), .out_last(out_last28), .out_ready(out_ready28)
  );

  // Pooling unit stand-ins: truncating mean of the four window pixels.
  int fin_delay;
  int fin_cnt4;
  logic [17:0] sum4, sum28;
  assign sum4  = 18'(p00_4) + 18'(p01_4) + 18'(p10_4) + 18'(p11_4);
  assign sum28 = 18'(p00_28) + 18'(p01_28) + 18'(p10_28) + 18'(p11_28);
  assign pool_pixel4   = sum4[17:2];
  assign pool_pixel28  = sum28[17:2];
  assign pool_finish4  = pool_start4 && (fin_cnt4 >= fin_delay);
  assign pool_finish28 = pool_start28;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              fin_cnt4 <= 0;
    else if (pool_start4 && !pool_finish4)   fin_cnt4 <= fin_cnt4 + 1;
    else                                     fin_cnt4 <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int unsigned      kind;      // 0: ramp 1..16, 1: constant 0x0100, 2: random
    bit               rnd_valid;
    int               stall;
    int               delay;
    bit               use_exp;
    logic [3:0][15:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic set_vec(input int i, input int unsigned kind, input bit rnd, input int stall,
                         input int delay, input bit use_exp, input logic [15:0] e0,
                         input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
    vecs[i].kind = kind; vecs[i].rnd_valid = rnd; vecs[i].stall = stall;
    vecs[i].delay = delay; vecs[i].use_exp = use_exp;
    vecs[i].exp[0] = e0; vecs[i].exp[1] = e1; vecs[i].exp[2] = e2; vecs[i].exp[3] = e3;
  endtask

  // Present one pixel, wait for acceptance, report wait length and accept cycle.
  task automatic drive_pix(input logic [15:0] d, output int t, output int acc_cyc);
    in_valid4 = 1'b1;
    in_data4  = d;
    t = 0;
    while (!in_ready4 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("in_handshake_in_time", 32'(t < 300), 32'd1);
    acc_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic run_frame(input int vi, input bit first);
    logic [15:0] pix  [16];
    logic [15:0] win  [4][4];
    logic [15:0] want [4];
    int          acc_q [$];
    vec_t        v;
    v = vecs[vi];
    for (int i = 0; i < 16; i++) begin
      case (v.kind)
        0:       pix[i] = 16'(i + 1);
        1:       pix[i] = 16'h0100;
        default: pix[i] = 16'($urandom);
      endcase
    end
    for (int w = 0; w < 4; w++) begin
      int r, c, s;
      r = (w / 2) * 2;
      c = (w % 2) * 2;
      win[w][0] = pix[r*4 + c];
      win[w][1] = pix[r*4 + c + 1];
      win[w][2] = pix[(r+1)*4 + c];
      win[w][3] = pix[(r+1)*4 + c + 1];
      s = int'(win[w][0]) + int'(win[w][1]) + int'(win[w][2]) + int'(win[w][3]);
      want[w] = v.use_exp ? v.exp[w] : 16'(s / 4);
    end
    fin_delay = v.delay;
    fork
      begin : drv
        for (int i = 0; i < 16; i++) begin
          int t, ac, idle;
          if (v.rnd_valid) begin
            idle = int'($urandom_range(0, 2));
            in_valid4 = 1'b0;
            repeat (idle) @(negedge clk);
          end
          drive_pix(pix[i], t, ac);
          if (i == 0 && !v.rnd_valid)
            chk($sformatf("first_accept_wait f%0d", vi), 32'(t), first ? 32'd0 : 32'd1);
          if (((i / 4) % 2 == 1) && (i % 2 == 1)) acc_q.push_back(ac);
        end
        in_valid4 = 1'b0;
      end
      begin : mon
        int got, t, stall_cnt, ps_len, wi;
        bit seen;
        got = 0; t = 0; stall_cnt = 0; ps_len = 0; wi = 0; seen = 1'b0;
        while (got < 4 && t < 2000) begin
          @(negedge clk);
          t++;
          if (pool_start4 || out_valid4) chk("in_ready_when_busy", 32'(in_ready4), 32'd0);
          if (pool_start4) begin
            ps_len++;
            if (wi < 4) begin
              chk($sformatf("p00 f%0d w%0d", vi, wi), 32'(p00_4), 32'(win[wi][0]));
              chk($sformatf("p01 f%0d w%0d", vi, wi), 32'(p01_4), 32'(win[wi][1]));
              chk($sformatf("p10 f%0d w%0d", vi, wi), 32'(p10_4), 32'(win[wi][2]));
              chk($sformatf("p11 f%0d w%0d", vi, wi), 32'(p11_4), 32'(win[wi][3]));
            end else begin
              chk("window_count", 32'(wi), 32'd3);
            end
          end else if (ps_len > 0) begin
            chk($sformatf("pool_start_len f%0d w%0d", vi, wi), 32'(ps_len), 32'(v.delay + 1));
            ps_len = 0;
            wi++;
          end
          if (out_valid4) begin
            if (!seen) begin
              seen = 1'b1;
              chk("latency_entry_present", 32'(acc_q.size() > 0), 32'd1);
              if (acc_q.size() > 0)
                chk($sformatf("latency f%0d o%0d", vi, got), 32'(cyc - acc_q.pop_front()),
                    32'(v.delay + 2));
            end
            if (stall_cnt < v.stall) begin
              out_ready4 = 1'b0;
              stall_cnt++;
            end else begin
              out_ready4 = 1'b1;
              chk($sformatf("out_data f%0d o%0d", vi, got), 32'(out_data4), 32'(want[got]));
              chk($sformatf("out_last f%0d o%0d", vi, got), 32'(out_last4), 32'(got == 3));
              got++;
              stall_cnt = 0;
              seen = 1'b0;
            end
          end else begin
            out_ready4 = (v.stall == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          end
        end
        chk($sformatf("outputs_per_frame f%0d", vi), 32'(got), 32'd4);
      end
    join
  endtask

  initial begin
    int t, ac, acc, outs;
    rst_n = 1'b0;
    in_valid4 = 1'b0;  in_data4 = '0;  out_ready4 = 1'b0;
    in_valid28 = 1'b0; in_data28 = '0; out_ready28 = 1'b0;
    fin_delay = 0;

    set_vec(0, 0, 1'b0, 0, 0, 1'b1, 16'd3,     16'd5,     16'd11,    16'd13);
    set_vec(1, 0, 1'b1, 5, 0, 1'b1, 16'd3,     16'd5,     16'd11,    16'd13);
    set_vec(2, 0, 1'b0, 0, 3, 1'b1, 16'd3,     16'd5,     16'd11,    16'd13);
    set_vec(3, 0, 1'b0, 0, 0, 1'b1, 16'd3,     16'd5,     16'd11,    16'd13);
    set_vec(4, 1, 1'b0, 0, 0, 1'b1, 16'h0100,  16'h0100,  16'h0100,  16'h0100);
    set_vec(5, 2, 1'b1, 2, 1, 1'b0, 16'd0,     16'd0,     16'd0,     16'd0);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst in_ready",   32'(in_ready4),   32'd0);
    chk("rst pool_start", 32'(pool_start4), 32'd0);
    chk("rst out_valid",  32'(out_valid4),  32'd0);
    chk("rst out_last",   32'(out_last4),   32'd0);
    chk("rst out_data",   32'(out_data4),   32'd0);
    chk("rst window",     32'(p00_4 | p01_4 | p10_4 | p11_4), 32'd0);
    chk("rst in_ready28", 32'(in_ready28),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst in_ready",   32'(in_ready4),  32'd1);
    chk("post_rst in_ready28", 32'(in_ready28), 32'd1);

    for (int vi = 0; vi < 6; vi++) run_frame(vi, vi == 0);

    out_ready4 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle no extra output", 32'(out_valid4), 32'd0);
    end

    // reset while an output is pending mid-frame
    out_ready4 = 1'b0;
    fin_delay  = 0;
    for (int i = 0; i < 6; i++) drive_pix(16'(i + 1), t, ac);
    in_valid4 = 1'b0;
    t = 0;
    while (!out_valid4 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("pending output before reset", 32'(out_valid4), 32'd1);
    chk("pending output value", 32'(out_data4), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst out_valid",  32'(out_valid4),  32'd0);
    chk("mid_rst in_ready",   32'(in_ready4),   32'd0);
    chk("mid_rst pool_start", 32'(pool_start4), 32'd0);
    chk("mid_rst out_data",   32'(out_data4),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after mid_rst in_ready",  32'(in_ready4),  32'd1);
    chk("after mid_rst out_valid", 32'(out_valid4), 32'd0);
    run_frame(0, 1'b1);

    // default geometry, constant frame
    in_data28   = 16'h0400;
    out_ready28 = 1'b1;
    in_valid28  = 1'b1;
    acc = 0; outs = 0; t = 0;
    while ((acc < 784 || outs < 196) && t < 5000) begin
      if (in_valid28 && in_ready28) acc++;
      @(negedge clk);
      t++;
      in_valid28 = (acc < 784);
      if (out_valid28) begin
        outs++;
        chk($sformatf("f28 data o%0d", outs), 32'(out_data28), 32'h0400);
        chk($sformatf("f28 last o%0d", outs), 32'(out_last28), 32'(outs == 196));
      end
    end
    in_valid28 = 1'b0;
    chk("f28 pixels accepted", 32'(acc),  32'd784);
    chk("f28 outputs",         32'(outs), 32'd196);
    repeat (4) begin
      @(negedge clk);
      chk("f28 no extra output", 32'(out_valid28), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
